// File: rtl/fetch_pc_sel_if.sv
// fetch_pc_sel_if: BTB, execute-resolve and fetch-side signals of the next-PC unit.
interface fetch_pc_sel_if;
    logic        stall;
    logic        btb_hit;
    logic [31:0] btb_ppc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        pred_taken;
    logic [31:0] pred_next_pc;
    logic        flush;
    logic        btb_start;
    logic        btb_update;
    logic [31:0] btb_update_pc;
    logic [31:0] btb_update_target;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output stall, btb_hit, btb_ppc, ex_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  fetch_pc, fetch_valid, pred_taken, pred_next_pc, flush, btb_start,
               btb_update, btb_update_pc, btb_update_target, branch_count, mispredict_count
    );

    modport slave (
        input  stall, btb_hit, btb_ppc, ex_valid, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output fetch_pc, fetch_valid, pred_taken, pred_next_pc, flush, btb_start,
               btb_update, btb_update_pc, btb_update_target, branch_count, mispredict_count
    );
endinterface

// File: rtl/fetch_pc_sel.sv
// fetch_pc_sel: fetch PC owner; BTB + 2-bit PHT prediction, execute-resolve redirect,
// PHT training and registered BTB update.
module fetch_pc_sel #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IDX_BITS = 5,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input logic            clk,
    input logic            rst,
    fetch_pc_sel_if.slave  bus
);
    localparam int N = 1 << IDX_BITS;

    logic [1:0]          r_pht [N];
    logic [31:0]         r_fetch_pc;
    logic                r_fetch_valid;
    logic                r_btb_start;
    logic                r_btb_update;
    logic [31:0]         r_btb_update_pc;
    logic [31:0]         r_btb_update_target;
    logic [31:0]         r_branch_count;
    logic [31:0]         r_mispredict_count;
    logic [IDX_BITS-1:0] w_idx;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [1:0]          w_ex_cnt;
    logic [1:0]          w_ex_cnt_nxt;
    logic                w_pred_taken;
    logic [31:0]         w_pred_next_pc;
    logic                w_mis;
    logic [31:0]         w_correct_pc;
    logic [31:0]         w_fetch_pc_nxt;

    assign w_idx          = r_fetch_pc[IDX_BITS+1:2];
    assign w_ex_idx       = bus.ex_pc[IDX_BITS+1:2];
    assign w_ex_cnt       = r_pht[w_ex_idx];
    assign w_pred_taken   = bus.btb_hit & r_pht[w_idx][1];
    assign w_pred_next_pc = w_pred_taken ? bus.btb_ppc : r_fetch_pc + 32'd4;
    assign w_mis          = bus.ex_valid & ((bus.ex_taken != bus.ex_pred_taken) |
                            (bus.ex_taken & (bus.ex_target != bus.ex_pred_target)));
    assign w_correct_pc   = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;

    always_comb begin
        w_ex_cnt_nxt   = bus.ex_taken ? ((w_ex_cnt == 2'b11) ? 2'b11 : w_ex_cnt + 2'd1)
                                      : ((w_ex_cnt == 2'b00) ? 2'b00 : w_ex_cnt - 2'd1);
        // A redirect outranks decode back-pressure.
        w_fetch_pc_nxt = w_mis ? w_correct_pc : bus.stall ? r_fetch_pc : w_pred_next_pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_pht[i] <= CNT_INIT;
            r_fetch_pc          <= RESET_PC;
            r_fetch_valid       <= 1'b0;
            r_btb_start         <= 1'b1;
            r_btb_update        <= 1'b0;
            r_btb_update_pc     <= 32'd0;
            r_btb_update_target <= 32'd0;
            r_branch_count      <= 32'd0;
            r_mispredict_count  <= 32'd0;
        end else begin
            if (bus.ex_valid) r_pht[w_ex_idx] <= w_ex_cnt_nxt;
            r_fetch_pc         <= w_fetch_pc_nxt;
            r_fetch_valid      <= ~w_mis;
            r_btb_start        <= 1'b0;
            r_btb_update       <= bus.ex_valid & bus.ex_taken;
            if (bus.ex_valid & bus.ex_taken) begin
                r_btb_update_pc     <= bus.ex_pc;
                r_btb_update_target <= bus.ex_target;
            end
            r_branch_count     <= r_branch_count + {31'd0, bus.ex_valid};
            r_mispredict_count <= r_mispredict_count + {31'd0, w_mis};
        end
    end

    assign bus.fetch_pc          = r_fetch_pc;
    assign bus.fetch_valid       = r_fetch_valid;
    assign bus.pred_taken        = w_pred_taken;
    assign bus.pred_next_pc      = w_pred_next_pc;
    assign bus.flush             = w_mis;
    assign bus.btb_start         = r_btb_start;
    assign bus.btb_update        = r_btb_update;
    assign bus.btb_update_pc     = r_btb_update_pc;
    assign bus.btb_update_target = r_btb_update_target;
    assign bus.branch_count      = r_branch_count;
    assign bus.mispredict_count  = r_mispredict_count;
endmodule

// File: tb/tb_fetch_pc_sel.sv
// tb_fetch_pc_sel: vector table with a post-edge scoreboard queue, plus hand sequences for
// PHT saturation, PC wrap and asynchronous reset.
module tb_fetch_pc_sel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fetch_pc_sel_if bus ();

    fetch_pc_sel dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, hit;
        logic [31:0] ppc;
        logic        exv;
        logic [31:0] expc;
        logic        ext;
        logic [31:0] extgt;
        logic        expt;
        logic [31:0] exptgt;
        logic        e_flush, e_pt;
        logic [31:0] e_pnpc;
        logic [31:0] e_fpc;
        logic        e_fv;
        logic [31:0] e_bc, e_mc;
        logic        e_bu;
        logic [31:0] e_bupc, e_butgt;
    } vec_t;

    typedef struct {
        logic [31:0] fpc;
        logic        fv;
        logic [31:0] bc, mc;
        logic        bu;
        logic [31:0] bupc, butgt;
    } exp_t;

    vec_t vecs[11];
    exp_t sb[$];

    function automatic vec_t mk(input int s, h, p, xv, xpc, xt, xtg, xpt, xptg,
                                input int f, pt, pn, fpc, fv, bc, mc, bu, bpc, btg);
        vec_t v;
        v.stall = s[0]; v.hit = h[0]; v.ppc = p; v.exv = xv[0]; v.expc = xpc;
        v.ext = xt[0]; v.extgt = xtg; v.expt = xpt[0]; v.exptgt = xptg;
        v.e_flush = f[0]; v.e_pt = pt[0]; v.e_pnpc = pn; v.e_fpc = fpc; v.e_fv = fv[0];
        v.e_bc = bc; v.e_mc = mc; v.e_bu = bu[0]; v.e_bupc = bpc; v.e_butgt = btg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, h, input logic [31:0] p, input logic xv,
                         input logic [31:0] xpc, input logic xt, input logic [31:0] xtg,
                         input logic xpt, input logic [31:0] xptg);
        bus.stall = s; bus.btb_hit = h; bus.btb_ppc = p; bus.ex_valid = xv; bus.ex_pc = xpc;
        bus.ex_taken = xt; bus.ex_target = xtg; bus.ex_pred_taken = xpt; bus.ex_pred_target = xptg;
    endtask

    task automatic step(input logic s, h, input logic [31:0] p, input logic xv,
                        input logic [31:0] xpc, input logic xt, input logic [31:0] xtg,
                        input logic xpt, input logic [31:0] xptg);
        drive(s, h, p, xv, xpc, xt, xtg, xpt, xptg);
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        //             st h  ppc    v  expc  t  tgt    pt ptgt    fl pt pnpc   fpc    fv bc mc bu bupc  butgt
        vecs[0]  = mk(0, 0, 0,     0, 0,    0, 0,     0, 0,      0, 0, 'h4,   'h4,   1, 0, 0, 0, 0,    0);
        vecs[1]  = mk(0, 0, 0,     0, 0,    0, 0,     0, 0,      0, 0, 'h8,   'h8,   1, 0, 0, 0, 0,    0);
        vecs[2]  = mk(0, 1, 'h100, 0, 0,    0, 0,     0, 0,      0, 0, 'hC,   'hC,   1, 0, 0, 0, 0,    0);
        vecs[3]  = mk(1, 1, 'h100, 1, 'hC,  1, 'h200, 1, 'h200,  0, 0, 'h10,  'hC,   1, 1, 0, 1, 'hC,  'h200);
        vecs[4]  = mk(0, 1, 'h100, 0, 0,    0, 0,     0, 0,      0, 1, 'h100, 'h100, 1, 1, 0, 0, 'hC,  'h200);
        vecs[5]  = mk(1, 0, 0,     1, 'h40, 1, 'h80,  0, 'h44,   1, 0, 'h104, 'h80,  0, 2, 1, 1, 'h40, 'h80);
        vecs[6]  = mk(0, 0, 0,     0, 0,    0, 0,     0, 0,      0, 0, 'h84,  'h84,  1, 2, 1, 0, 'h40, 'h80);
        vecs[7]  = mk(0, 0, 0,     1, 'h84, 0, 'h999, 0, 'h88,   0, 0, 'h88,  'h88,  1, 3, 1, 0, 'h40, 'h80);
        vecs[8]  = mk(0, 0, 0,     1, 'h60, 0, 0,     1, 'h300,  1, 0, 'h8C,  'h64,  0, 4, 2, 0, 'h40, 'h80);
        vecs[9]  = mk(0, 0, 0,     1, 'h20, 1, 'h500, 1, 'h504,  1, 0, 'h68,  'h500, 0, 5, 3, 1, 'h20, 'h500);
        vecs[10] = mk(0, 0, 0,     0, 0,    0, 0,     0, 0,      0, 0, 'h504, 'h504, 1, 5, 3, 0, 'h20, 'h500);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset fetch_pc", bus.fetch_pc, 32'h0);
        chk("reset fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
        chk("reset btb_start", {31'd0, bus.btb_start}, 32'd1);
        chk("reset btb_update", {31'd0, bus.btb_update}, 32'd0);
        chk("reset btb_update_pc", bus.btb_update_pc, 32'h0);
        chk("reset btb_update_target", bus.btb_update_target, 32'h0);
        chk("reset branch_count", bus.branch_count, 32'd0);
        chk("reset mispredict_count", bus.mispredict_count, 32'd0);
        rst = 1'b0;
        #1;
        chk("btb_start before first edge", {31'd0, bus.btb_start}, 32'd1);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].stall, vecs[i].hit, vecs[i].ppc, vecs[i].exv, vecs[i].expc,
                  vecs[i].ext, vecs[i].extgt, vecs[i].expt, vecs[i].exptgt);
            #1;
            chk($sformatf("r%0d flush", i), {31'd0, bus.flush}, {31'd0, vecs[i].e_flush});
            chk($sformatf("r%0d pred_taken", i), {31'd0, bus.pred_taken}, {31'd0, vecs[i].e_pt});
            chk($sformatf("r%0d pred_next_pc", i), bus.pred_next_pc, vecs[i].e_pnpc);
            sb.push_back('{vecs[i].e_fpc, vecs[i].e_fv, vecs[i].e_bc, vecs[i].e_mc,
                           vecs[i].e_bu, vecs[i].e_bupc, vecs[i].e_butgt});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("r%0d fetch_pc", i), bus.fetch_pc, e.fpc);
            chk($sformatf("r%0d fetch_valid", i), {31'd0, bus.fetch_valid}, {31'd0, e.fv});
            chk($sformatf("r%0d branch_count", i), bus.branch_count, e.bc);
            chk($sformatf("r%0d mispredict_count", i), bus.mispredict_count, e.mc);
            chk($sformatf("r%0d btb_update", i), {31'd0, bus.btb_update}, {31'd0, e.bu});
            chk($sformatf("r%0d btb_update_pc", i), bus.btb_update_pc, e.bupc);
            chk($sformatf("r%0d btb_update_target", i), bus.btb_update_target, e.butgt);
            if (i == 0) chk("btb_start after first edge", {31'd0, bus.btb_start}, 32'd0);
            @(negedge clk);
        end

        // PHT saturation on index of pc 0x30, fetch held there by stall.
        step(0, 0, 0, 1, 32'h0, 1, 32'h30, 0, 32'h0);
        chk("sat redirect fetch_pc", bus.fetch_pc, 32'h30);
        repeat (4) step(1, 1, 32'h700, 1, 32'h30, 1, 32'h34, 1, 32'h34);
        chk("sat taken x4 pred_taken", {31'd0, bus.pred_taken}, 32'd1);
        chk("sat taken x4 pred_next_pc", bus.pred_next_pc, 32'h700);
        step(1, 1, 32'h700, 1, 32'h30, 0, 32'h0, 0, 32'h0);
        chk("sat 11 minus 1 pred_taken", {31'd0, bus.pred_taken}, 32'd1);
        repeat (3) step(1, 1, 32'h700, 1, 32'h30, 0, 32'h0, 0, 32'h0);
        chk("sat not-taken floor pred_taken", {31'd0, bus.pred_taken}, 32'd0);
        chk("sat floor pred_next_pc", bus.pred_next_pc, 32'h34);
        step(1, 1, 32'h700, 1, 32'h30, 1, 32'h34, 1, 32'h34);
        chk("sat 00 plus 1 pred_taken", {31'd0, bus.pred_taken}, 32'd0);
        step(1, 1, 32'h700, 1, 32'h30, 1, 32'h34, 1, 32'h34);
        chk("sat 01 plus 1 pred_taken", {31'd0, bus.pred_taken}, 32'd1);
        chk("sat stall held fetch_pc", bus.fetch_pc, 32'h30);

        // Fetch PC wraps past the top of the address space.
        step(0, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0);
        chk("wrap redirect fetch_pc", bus.fetch_pc, 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("wrap pred_next_pc", bus.pred_next_pc, 32'h0);
        @(posedge clk);
        #1;
        chk("wrap fetch_pc", bus.fetch_pc, 32'h0);

        // Asynchronous reset drops a pending BTB update.
        step(0, 0, 0, 1, 32'h10, 1, 32'h90, 1, 32'h90);
        chk("pre-reset btb_update", {31'd0, bus.btb_update}, 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("async rst btb_update", {31'd0, bus.btb_update}, 32'd0);
        chk("async rst fetch_pc", bus.fetch_pc, 32'h0);
        chk("async rst branch_count", bus.branch_count, 32'd0);
        chk("async rst btb_update_pc", bus.btb_update_pc, 32'h0);
        chk("async rst btb_start", {31'd0, bus.btb_start}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("re-release btb_start", {31'd0, bus.btb_start}, 32'd1);
        @(posedge clk);
        #1;
        chk("re-release btb_start low", {31'd0, bus.btb_start}, 32'd0);
        chk("re-release fetch_valid", {31'd0, bus.fetch_valid}, 32'd1);
        chk("re-release fetch_pc", bus.fetch_pc, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
